nes_audio_decim: RTL and testbench
==================================

NES_AUDIO_DECIM -- requirements
Module: nes_audio_decim

Interface
REQ-001 Parameter CLK_DIV, default 448, meaning clk cycles per output sample window (21.477 MHz / 48 kHz); legal range 64..4095.
REQ-002 Derived constant ACC_W = 16 + clog2(CLK_DIV+1), meaning accumulator and dividend width (25 for the default).
REQ-003 clk  input  1  NES clock; all state on rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 sample_in  input  16  unsigned APU mixer sample.
REQ-006 sample_valid  input  1  sample_in is accumulated this cycle.
REQ-007 volume  input  4  output gain select; 15 = unity.
REQ-008 mute  input  1  force output sample to zero.
REQ-009 sample_out  output  16  decimated unsigned sample, held between strobes.
REQ-010 sample_strobe  output  1  one-cycle pulse; sample_out updated the same cycle.
REQ-011 busy  output  1  high while the divider/scaler is processing a closed window.

Function
REQ-012 Window counter wcnt SHALL count 0..CLK_DIV-1 every clk, wrap to 0, and run independent of sample_valid.
REQ-013 Each cycle with sample_valid=1 SHALL add zero-extended sample_in to accumulator acc (ACC_W bits) and increment valid count vcnt (clog2(CLK_DIV+1) bits); acc SHALL never overflow.
REQ-014 On the close cycle (wcnt==CLK_DIV-1), that cycle's sample SHALL be included, then {acc,vcnt} SHALL be copied to divider registers and acc/vcnt cleared, so the next window starts with no gap and no lost sample.
REQ-015 State machine: IDLE -> DIV on close cycle; DIV runs exactly ACC_W cycles of restoring division (one quotient bit per cycle, MSB first); DIV -> SCALE; SCALE -> IDLE after one cycle; busy=1 in DIV and SCALE.
REQ-016 Quotient q = floor(acc/vcnt), truncated to 16 bits (always fits because each sample is at most 0xFFFF).
REQ-017 If vcnt==0 at close, DIV SHALL still take ACC_W cycles and q SHALL equal the previous unscaled q (hold), so latency is fixed.
REQ-018 SCALE SHALL compute sample_out = mute ? 0 : (q*(volume+1))>>4; volume and mute are sampled in the SCALE cycle only.
REQ-019 sample_strobe SHALL pulse high for exactly one cycle, ACC_W+2 cycles after the close-cycle edge, once per window, and also when muted.
REQ-020 Because CLK_DIV >= 64 > ACC_W+2, a new close SHALL never occur outside IDLE; elaboration SHALL fail for CLK_DIV outside 64..4095.
REQ-021 sample_out SHALL change only on a strobe cycle.

Reset
REQ-022 While resetn=0: sample_out=0, sample_strobe=0, busy=0, wcnt=0, acc=0, vcnt=0, held q=0, state IDLE, taking effect without a clock edge.
REQ-023 A reset asserted mid-DIV or mid-SCALE SHALL abort with no strobe; after release the first window is a full CLK_DIV cycles starting at wcnt=0.
REQ-024 Release SHALL be synchronized internally (two-flop deassert), with the first counted cycle defined as the first edge after sync release.

Verification
REQ-025 Reset: resetn=0 with random inputs -> sample_out=0x0000, sample_strobe=0, busy=0 immediately and throughout.
REQ-026 sample_in=0x1234, valid every cycle, volume=15 -> first strobe 27 cycles after the first close; sample_out=0x1234; strobes exactly 448 cycles apart.
REQ-027 Alternating 0x0000/0xFFFF, valid every cycle -> sample_out=0x7FFF (floor of 32767.5); then valid on one cycle per window only, value 0x8000 -> 0x8000.
REQ-028 After an output of 0x1234, a window with sample_valid=0 throughout -> strobe at nominal time with sample_out=0x1234.
REQ-029 Constant 0x1000, volume=7 -> 0x0800; mute=1 -> 0x0000 with the strobe still present; mute toggled outside SCALE has no effect.
REQ-030 resetn pulsed low 10 cycles into DIV -> no strobe for that window; next strobe 448+27 cycles after sync release with the correct average.

Source files
------------

// File: rtl/nes_audio_decim.sv
// Decimating averager for the NES APU mixer output. Each CLK_DIV-cycle window
// is averaged, the average is scaled by a 4-bit volume, and one sample is emitted per window.
module nes_audio_decim #(
  parameter int CLK_DIV = 448
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  input  logic [3:0]  volume,
  input  logic        mute,
  output logic [15:0] sample_out,
  output logic        sample_strobe,
  output logic        busy
);

  localparam int CNT_W  = $clog2(CLK_DIV + 1);
  localparam int ACC_W  = 16 + CNT_W;
  localparam int WCNT_W = $clog2(CLK_DIV);
  localparam int BCNT_W = $clog2(ACC_W);

  // The divider needs far fewer cycles than a window, so a close can only ever
  // happen while the FSM is idle.
  if (CLK_DIV < 64 || CLK_DIV > 4095) begin : g_clk_div_range
    $error("nes_audio_decim: CLK_DIV must be within 64..4095");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_SCALE = 2'd2
  } state_e;

  state_e state, state_nxt;

  logic [1:0]        rst_sync;
  logic              run;
  logic [WCNT_W-1:0] wcnt;
  logic              close;
  logic [ACC_W-1:0]  acc, acc_next;
  logic [CNT_W-1:0]  vcnt, vcnt_next;

  logic [ACC_W-1:0]  quo;
  logic [CNT_W-1:0]  dvs;
  logic [CNT_W-1:0]  rem;
  logic              zero_div;
  logic [BCNT_W-1:0] bcnt;
  logic [15:0]       q_hold;

  logic [CNT_W:0]    trial;
  logic              trial_ge;
  logic [CNT_W-1:0]  trial_rem;
  logic [15:0]       q_sel;
  logic [4:0]        vol_p1;
  logic [20:0]       prod;
  logic [15:0]       scaled;

  // Reset asserts asynchronously but leaves through two flops, so the first
  // counted edge is the one after rst_sync[1] rises.
  // NOTE: every clocked block uses non-blocking assignments so that all flops
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run       = rst_sync[1];
  assign close     = run && (wcnt == WCNT_W'(CLK_DIV - 1));
  assign acc_next  = acc + (sample_valid ? ACC_W'(sample_in) : '0);
  assign vcnt_next = vcnt + CNT_W'(sample_valid);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wcnt <= '0;
      acc  <= '0;
      vcnt <= '0;
    end else if (!run) begin
      wcnt <= '0;
      acc  <= '0;
      vcnt <= '0;
    end else if (close) begin
      wcnt <= '0;
      acc  <= '0;
      vcnt <= '0;
    end else begin
      wcnt <= wcnt + WCNT_W'(1);
      acc  <= acc_next;
      vcnt <= vcnt_next;
    end
  end

  // Restoring division: the dividend shifts out of the top of quo while the
  // quotient bits shift in at the bottom.
  assign trial     = {rem, quo[ACC_W-1]};
  assign trial_ge  = trial >= {1'b0, dvs};
  assign trial_rem = trial_ge ? CNT_W'(trial - {1'b0, dvs}) : trial[CNT_W-1:0];

  assign q_sel  = zero_div ? q_hold : quo[15:0];
  assign vol_p1 = {1'b0, volume} + 5'd1;
  assign prod   = 21'(q_sel) * 21'(vol_p1);
  assign scaled = mute ? 16'h0000 : 16'(prod >> 4);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else if (!run) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the next-state logic assigns its default first, so no path through
  // the case statement leaves state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (close) state_nxt = S_DIV;
      S_DIV:   if (bcnt == BCNT_W'(ACC_W - 1)) state_nxt = S_SCALE;
      S_SCALE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo      <= '0;
      dvs      <= '0;
      rem      <= '0;
      zero_div <= 1'b0;
      bcnt     <= '0;
    end else if (!run) begin
      quo      <= '0;
      dvs      <= '0;
      rem      <= '0;
      zero_div <= 1'b0;
      bcnt     <= '0;
    end else if (close) begin
      quo      <= acc_next;
      dvs      <= vcnt_next;
      rem      <= '0;
      zero_div <= (vcnt_next == '0);
      bcnt     <= '0;
    end else if (state == S_DIV) begin
      quo  <= {quo[ACC_W-2:0], trial_ge};
      rem  <= trial_rem;
      bcnt <= bcnt + BCNT_W'(1);
    end
  end

  // An empty window divides by zero; its result is discarded in favour of the
  // last real quotient, which keeps the output latency fixed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_hold        <= '0;
      sample_out    <= '0;
      sample_strobe <= 1'b0;
    end else if (!run) begin
      q_hold        <= '0;
      sample_out    <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= (state == S_SCALE);
      if (state == S_SCALE) begin
        q_hold     <= q_sel;
        sample_out <= scaled;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_nes_audio_decim.sv
// Self-checking bench for nes_audio_decim: windows of directed and random
// stimulus, checked every cycle against a window-average reference model.
module tb_nes_audio_decim;

  localparam int CLK_DIV = 448;
  localparam int CNT_W   = $clog2(CLK_DIV + 1);
  localparam int ACC_W   = 16 + CNT_W;
  // Output of a window appears in this cycle of the following window.
  localparam int STROBE_J = ACC_W + 1;
  localparam int SCALE_J  = ACC_W;

  typedef enum int {K_CONST, K_ALT, K_ONE, K_NONE, K_RAND} kind_e;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [3:0]  volume = 4'd15;
  logic        mute = 1'b0;
  logic [15:0] sample_out;
  logic        sample_strobe;
  logic        busy;

  nes_audio_decim #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .volume       (volume),
    .mute         (mute),
    .sample_out   (sample_out),
    .sample_strobe(sample_strobe),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  bit          pend;         // a closed window awaits its output
  int unsigned pend_q;       // unscaled average of that window
  int unsigned last_q;       // last unscaled average (for empty windows)
  int unsigned scaled_out;   // value due at the next strobe
  int unsigned held_out;     // what sample_out should show now

  // Stimulus controls.
  logic [3:0]  scale_vol = 4'd15;
  logic        scale_mute = 1'b0;
  bit          noise = 1'b0;
  int          one_pos = 0;
  int          valid_pct = 75;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_inputs();
    sample_in    = 16'($urandom);
    sample_valid = 1'($urandom);
    volume       = 4'($urandom);
    mute         = 1'($urandom);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out"},    32'(sample_out),    32'h0);
    check({tag, "_strobe"}, 32'(sample_strobe), 32'h0);
    check({tag, "_busy"},   32'(busy),          32'h0);
  endtask

  // Called at a negedge: asserts reset, holds it, then releases and runs the
  // two synchronizer cycles, leaving the next negedge as window cycle 0.
  task automatic reset_cycle(input int hold);
    resetn = 1'b0;
    rand_inputs();
    #1;
    check_zero("rst_now");
    pend = 1'b0; last_q = 0; held_out = 0; scaled_out = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      rand_inputs();
      #1;
      check_zero("rst_hold");
    end
    @(negedge clk);
    resetn = 1'b1;
    rand_inputs();
    @(negedge clk);
    check_zero("rst_sync");
    rand_inputs();
  endtask

  task automatic drive_window(input kind_e kind, input logic [15:0] val,
                              input int len = CLK_DIV, input int abort_at = -1);
    longint unsigned sum = 0;
    int unsigned cnt = 0;
    logic v;
    logic [15:0] d;
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      // Observe outputs produced by the previous window.
      if (pend && j == STROBE_J) held_out = scaled_out;
      check("strobe", 32'(sample_strobe), 32'(pend && j == STROBE_J));
      check("busy",   32'(busy),          32'(pend && j <= SCALE_J));
      check("out",    32'(sample_out),    held_out);
      if (pend && j == STROBE_J) pend = 1'b0;
      if (j == abort_at) begin
        reset_cycle(3);
        return;
      end
      d = 16'($urandom);
      case (kind)
        K_CONST: begin v = 1'b1; d = val; end
        K_ALT:   begin v = 1'b1; d = (j % 2 == 1) ? 16'hFFFF : 16'h0000; end
        K_ONE:   begin v = (j == one_pos); if (v) d = val; end
        K_NONE:  v = 1'b0;
        default: v = ($urandom_range(0, 99) < valid_pct);
      endcase
      sample_in    = d;
      sample_valid = v;
      if (j == SCALE_J || !noise) begin
        volume = scale_vol;
        mute   = scale_mute;
      end else begin
        volume = 4'($urandom);
        mute   = 1'($urandom);
      end
      if (pend && j == SCALE_J)
        scaled_out = mute ? 0 : (pend_q * (32'(volume) + 1)) / 16;
      if (v) begin
        sum += d;
        cnt++;
      end
    end
    if (len == CLK_DIV) begin
      pend_q = (cnt == 0) ? last_q : int'(sum / cnt) & 32'hFFFF;
      last_q = pend_q;
      pend   = 1'b1;
    end
  endtask

  initial begin
    pend = 1'b0; last_q = 0; held_out = 0; scaled_out = 0; pend_q = 0;
    rand_inputs();
    #1;
    check_zero("por");
    @(negedge clk);
    reset_cycle(4);

    // Constant input at unity gain, then an empty window that must hold.
    drive_window(K_CONST, 16'h1234);
    drive_window(K_CONST, 16'h1234);
    drive_window(K_NONE,  16'h0000);
    // Alternating extremes average to 0x7FFF.
    drive_window(K_ALT,   16'h0000);
    drive_window(K_ALT,   16'h0000);
    // One valid sample per window, including on the close cycle itself.
    one_pos = $urandom_range(0, CLK_DIV - 2);
    drive_window(K_ONE,   16'h8000);
    one_pos = CLK_DIV - 1;
    drive_window(K_ONE,   16'h8000);
    one_pos = 0;
    drive_window(K_ONE,   16'hBEEF);
    // Gain and mute.
    scale_vol = 4'd7;
    drive_window(K_CONST, 16'h1000);
    drive_window(K_CONST, 16'h1000);
    scale_mute = 1'b1;
    drive_window(K_CONST, 16'h1000);
    scale_mute = 1'b0;
    scale_vol  = 4'd15;
    noise      = 1'b1;
    drive_window(K_CONST, 16'h1000);
    drive_window(K_CONST, 16'h4321);
    noise = 1'b0;

    // Reset ten cycles into the divider: that window never produces output.
    drive_window(K_CONST, 16'h2222);
    drive_window(K_CONST, 16'h5555, CLK_DIV, 10);
    drive_window(K_CONST, 16'h3333);
    drive_window(K_RAND,  16'h0000);

    // Random windows with random gain/mute and noisy controls.
    noise = 1'b1;
    for (int w = 0; w < 6; w++) begin
      scale_vol  = 4'($urandom);
      scale_mute = ($urandom_range(0, 4) == 0);
      valid_pct  = (w == 2) ? 1 : int'($urandom_range(10, 100));
      drive_window(K_RAND, 16'h0000);
    end
    drive_window(K_RAND, 16'h0000, STROBE_J + 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
